rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Writer-side counterpart to the instruction ROM. Receives a Hack program as a byte stream and writes it into the ROM write port as 16-bit words, starting at address 0 and incrementing.
- Holds the CPU in reset while a load is in progress.
- Provides hardware program loading in place of simulation-only $readmemb preloading.

Parameters:
ADDR_W, 15, ROM word-address width (ROM depth = 2**ADDR_W words)
DATA_W, 16, ROM word width; fixed at 16, two bytes per word

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_n_i  input  1  asynchronous, active-low reset
start_i  input  1  begin a load; sampled only in IDLE
len_i  input  ADDR_W+1  number of words to load; latched on accepted start
byte_valid_i  input  1  byte_data_i is valid
byte_data_i  input  8  incoming program byte
byte_ready_o  output  1  loader accepts a byte this cycle
we_o  output  1  ROM write enable, one-cycle pulse per word
waddr_o  output  ADDR_W  ROM write address
wdata_o  output  DATA_W  ROM write data
busy_o  output  1  load in progress
cpu_rst_o  output  1  CPU hold-in-reset; equals busy_o
done_o  output  1  one-cycle pulse at end of load

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE. All outputs 0, word counter 0, byte registers 0. Takes effect immediately, including mid-load. Words already written stay in ROM. No further we_o is issued.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- States: IDLE, HI, LO, WR, DONE.
- IDLE:
  - byte_ready_o=0, busy_o=0.
  - start_i=1 and len_i==0 -> DONE.
  - start_i=1 and len_i>0 -> latch len (values > 2**ADDR_W clamp to 2**ADDR_W), clear counter, go to HI.
- HI: byte_ready_o=1. When byte_valid_i & byte_ready_o, capture the high byte -> LO.
- LO: byte_ready_o=1. When byte_valid_i & byte_ready_o, capture the low byte -> WR.
- Byte order: high byte first (MSB-first, matching .hack text bit order).
- WR:
  - byte_ready_o=0.
  - we_o=1, waddr_o=counter, wdata_o={hi,lo}.
  - Counter increments.
  - If counter+1 == len -> DONE, else -> HI.
- DONE: done_o=1 for exactly one cycle, busy_o=0 -> IDLE.
- busy_o / cpu_rst_o: high in HI, LO and WR; low in IDLE and DONE.
- Latency:
  - Low-byte handshake at cycle N -> we_o at N+1.
  - Last word written at N+1 -> done_o at N+2.
  - start_i accepted at cycle S -> byte_ready_o high at S+1.
- Back-pressure: byte_valid_i low in HI/LO stalls indefinitely with no state change. Bytes offered while byte_ready_o=0 are not consumed.
- start_i outside IDLE is ignored; len_i changes after latch have no effect.
- waddr_o never wraps. At the maximum length, the final write is to address 2**ADDR_W-1, then DONE.
- waddr_o/wdata_o hold their last written values when we_o=0.

Test Plan:
- Reset: assert rst_n_i=0 mid-simulation -> same cycle: byte_ready_o, we_o, busy_o, cpu_rst_o, done_o all 0.
- Add program: len_i=6, bytes 00 02 EC 10 00 03 E0 90 00 00 E3 08, byte_valid_i held high.
  - Six we_o pulses: addr 0..5, data 0x0002, 0xEC10, 0x0003, 0xE090, 0x0000, 0xE308.
  - done_o one cycle after the addr-5 write.
  - Reading the rom addr_i 0..5 afterwards returns the same words.
- Back-pressure: same load with byte_valid_i low for 3 random cycles between bytes -> identical write sequence; state holds during gaps; no extra we_o.
- Zero length: start_i with len_i=0 -> done_o one cycle later; no we_o; busy_o stays 0.
- Abort and restart:
  - Pulse start_i while busy -> ignored.
  - Drop rst_n_i after 3 words written -> immediate IDLE; addrs 0..2 keep their data; no we_o.
  - A new load of 2 words -> writes to addr 0 and 1.
- Clamp: len_i=16'hFFFF -> exactly 32768 writes; last waddr_o=0x7FFF; no write to 0 afterwards; done_o pulses once.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: writer-side counterpart to the instruction ROM.
//
// Receives a Hack program as a byte stream, high byte first, and writes it
// into the ROM write port as 16-bit words at consecutive addresses starting
// at 0. The CPU is held in reset (cpu_rst_o) while a load is in progress.
//
// Ports:
//   clk_i          clock, rising-edge
//   rst_n_i        asynchronous active-low reset
//   start_i        begin a load (sampled only in IDLE)
//   len_i          word count, latched on an accepted start, clamped to 2**ADDR_W
//   byte_valid_i   byte_data_i carries a valid byte
//   byte_data_i    program byte
//   byte_ready_o   loader takes a byte this cycle (HI/LO states)
//   we_o           ROM write enable, one pulse per word
//   waddr_o        ROM write address (holds last written value)
//   wdata_o        ROM write data (holds last written value)
//   busy_o         load in progress (HI/LO/WR)
//   cpu_rst_o      CPU hold-in-reset, equal to busy_o
//   done_o         one-cycle pulse at the end of a load
//   dbg_state_o    current FSM state (0 IDLE, 1 HI, 2 LO, 3 WR, 4 DONE)
//
// Handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both high; byte_ready_o depends only on registered state,
// and a source may hold byte_valid_i high indefinitely or drop it at will.
module rom_loader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Largest legal length: the full ROM depth.
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     cnt_q;     // one bit wider than the address so it can equal LEN_MAX
  logic [ADDR_W:0]     cnt_nxt;
  logic [7:0]          hi_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;

  assign cnt_nxt = cnt_q + ONE;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              state_q <= S_DONE;
            end else begin
              len_q   <= (len_i > LEN_MAX) ? LEN_MAX : len_i;
              cnt_q   <= '0;
              state_q <= S_HI;
            end
          end
        end
        S_HI: begin
          if (byte_valid_i) begin
            hi_q    <= byte_data_i;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          // Address and data are loaded here so they are stable during the
          // WR pulse and keep their value until the next word completes.
          if (byte_valid_i) begin
            wdata_q <= {hi_q, byte_data_i};
            waddr_q <= cnt_q[ADDR_W-1:0];
            state_q <= S_WR;
          end
        end
        S_WR: begin
          cnt_q   <= cnt_nxt;
          state_q <= (cnt_nxt == len_q) ? S_DONE : S_HI;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs are decoded from registered state only.
  assign byte_ready_o = (state_q == S_HI) || (state_q == S_LO);
  assign we_o         = (state_q == S_WR);
  assign busy_o       = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WR);
  assign cpu_rst_o    = busy_o;
  assign done_o       = (state_q == S_DONE);
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: directed loads with hand-computed words.
// A second instance with an 8-bit address covers the length clamp at full
// depth in a short run.
module tb_rom_loader;
  localparam int AW  = 15;
  localparam int CAW = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // main instance
  logic          start;
  logic [AW:0]   len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic          busy;
  logic          cpu_rst;
  logic          done;
  logic [2:0]    dbg_state;

  // clamp instance
  logic           c_start;
  logic [CAW:0]   c_len;
  logic           c_valid;
  logic [7:0]     c_data;
  logic           c_ready;
  logic           c_we;
  logic [CAW-1:0] c_waddr;
  logic [15:0]    c_wdata;
  logic           c_busy;
  logic           c_cpu_rst;
  logic           c_done;
  logic [2:0]     c_dbg_state;

  rom_loader dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .busy_o(busy),
    .cpu_rst_o(cpu_rst), .done_o(done), .dbg_state_o(dbg_state)
  );

  rom_loader #(.ADDR_W(CAW)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(c_start), .len_i(c_len),
    .byte_valid_i(c_valid), .byte_data_i(c_data), .byte_ready_o(c_ready),
    .we_o(c_we), .waddr_o(c_waddr), .wdata_o(c_wdata), .busy_o(c_busy),
    .cpu_rst_o(c_cpu_rst), .done_o(c_done), .dbg_state_o(c_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [AW+15:0] exp_q[$];        // {addr, data} per expected write
  logic [15:0]    rom [0:63];      // model of ROM contents, filled from writes
  int             we_cnt = 0;
  int             done_cnt = 0;
  int             c_we_cnt = 0;
  int             c_done_cnt = 0;
  int             c_exp_addr = 0;
  logic [CAW-1:0] c_last_addr = '0;

  always @(negedge clk) begin
    logic [AW+15:0] e;
    if (we) begin
      we_cnt++;
      rom[waddr[5:0]] = wdata;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", 32'(waddr), 32'(e[AW+15:16]));
        check("we_data", 32'(wdata), 32'(e[15:0]));
      end
    end
    if (done) done_cnt++;
    if (c_we) begin
      check("clamp_addr", 32'(c_waddr), 32'(c_exp_addr));
      check("clamp_data", 32'(c_wdata), 32'h5A5A);
      c_exp_addr++;
      c_we_cnt++;
      c_last_addr = c_waddr;
    end
    if (c_done) c_done_cnt++;
  end

  // ---------------- driver tasks ----------------
  logic [15:0] cur [0:15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AW:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; all sampling is 1 ns after the edge.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_stall);
    bit got = 1'b0;
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (chk_stall) begin
        check("stall_state", 32'(dbg_state), 32'(S_LO));
        check("stall_ready", 32'(byte_ready), 32'd1);
      end
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 20 && !got; t++) begin
      if (byte_ready) got = 1'b1;
      tick();
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_word(input logic [15:0] w, input bit bp);
    send_byte(w[15:8], bp ? 3 * int'($urandom_range(0, 1)) : 0, 1'b0);
    send_byte(w[7:0],  bp ? 3 * int'($urandom_range(0, 1)) : 0, 1'b1);
    check("we_after_lo", 32'(we), 32'd1);
  endtask

  task automatic run_prog(input int n, input bit bp);
    for (int i = 0; i < n; i++) exp_q.push_back({i[AW-1:0], cur[i]});
    start_load(n[AW:0]);
    check("start_ready", 32'(byte_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < n; i++) load_word(cur[i], bp);
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_we", 32'(we), 32'd0);
    byte_valid = 1'b0;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("back_idle", 32'(dbg_state), 32'(S_IDLE));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_add_prog();
    cur[0] = 16'h0002; cur[1] = 16'hEC10; cur[2] = 16'h0003;
    cur[3] = 16'hE090; cur[4] = 16'h0000; cur[5] = 16'hE308;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'hDEAD;
  endtask

  task automatic check_add_rom(input string tag);
    check({tag, "_0"}, 32'(rom[0]), 32'h0002);
    check({tag, "_1"}, 32'(rom[1]), 32'hEC10);
    check({tag, "_2"}, 32'(rom[2]), 32'h0003);
    check({tag, "_3"}, 32'(rom[3]), 32'hE090);
    check({tag, "_4"}, 32'(rom[4]), 32'h0000);
    check({tag, "_5"}, 32'(rom[5]), 32'hE308);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int we_before;
    int done_before;
    bit fin;
    rst_n = 1'b1; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = '0;
    c_start = 1'b0; c_len = '0; c_valid = 1'b0; c_data = 8'h5A;
    clear_rom();
    #2 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // add program, valid held high
    set_add_prog();
    run_prog(6, 1'b0);
    check_add_rom("rom_nobp");
    repeat (2) tick();
    check("hold_waddr", 32'(waddr), 32'd5);
    check("hold_wdata", 32'(wdata), 32'hE308);

    // same program with back-pressure gaps
    clear_rom();
    we_before = we_cnt;
    run_prog(6, 1'b1);
    check_add_rom("rom_bp");
    check("bp_we_count", 32'(we_cnt - we_before), 32'd6);

    // zero length
    we_before = we_cnt;
    start_load('0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    tick();
    check("zero_done_once", 32'(done), 32'd0);
    check("zero_no_we", 32'(we_cnt - we_before), 32'd0);

    // abort: ignored start while busy, then reset after three words
    clear_rom();
    for (int i = 0; i < 3; i++) exp_q.push_back({i[AW-1:0], cur[i]});
    start_load(16'd6);
    load_word(cur[0], 1'b0);
    start = 1'b1; len = 16'd1;
    load_word(cur[1], 1'b0);
    start = 1'b0;
    check("busy_start_ignored", 32'(busy), 32'd1);
    load_word(cur[2], 1'b0);
    tick();
    check("abort_in_hi", 32'(byte_ready), 32'd1);
    we_before = we_cnt;
    byte_valid = 1'b1; byte_data = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(byte_ready), 32'd0);
    check("abort_we", 32'(we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (3) tick();
    check("abort_no_we", 32'(we_cnt - we_before), 32'd0);
    check("abort_rom_0", 32'(rom[0]), 32'h0002);
    check("abort_rom_1", 32'(rom[1]), 32'hEC10);
    check("abort_rom_2", 32'(rom[2]), 32'h0003);
    @(negedge clk) rst_n = 1'b1;
    byte_valid = 1'b0;
    tick();

    // restart with a two-word load
    cur[0] = 16'hABCD; cur[1] = 16'h1234;
    run_prog(2, 1'b0);
    check("restart_rom_0", 32'(rom[0]), 32'hABCD);
    check("restart_rom_1", 32'(rom[1]), 32'h1234);

    // clamp on the 8-bit-address instance: all-ones length -> 256 writes
    done_before = c_done_cnt;
    c_valid = 1'b1;
    c_len   = '1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    fin = 1'b0;
    for (int t = 0; t < 2000 && !fin; t++) begin
      if (c_done) fin = 1'b1;
      tick();
    end
    if (!fin) check("clamp_timeout", 32'd0, 32'd1);
    repeat (10) tick();
    c_valid = 1'b0;
    check("clamp_we_count", 32'(c_we_cnt), 32'd256);
    check("clamp_last_addr", 32'(c_last_addr), 32'hFF);
    check("clamp_done_once", 32'(c_done_cnt - done_before), 32'd1);
    check("clamp_busy", 32'(c_busy), 32'd0);

    check("total_done", 32'(done_cnt), 32'd4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
